// File: rtl/image_frame_streamer_if.sv
// Handshake bundle between the host byte source, the frame streamer and the CNN network.
// The streamer connects through the slave modport; the host/network side uses master.
interface image_frame_streamer_if #(
    parameter int DATA_BITS = 8,
    parameter int ID_BITS   = 8
);
    logic [DATA_BITS-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [DATA_BITS-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [3:0]           net_class;
    logic                 net_valid;
    logic [3:0]           res_class;
    logic [ID_BITS-1:0]   res_id;
    logic                 res_timeout;
    logic                 res_valid;
    logic                 stray_err;
    logic                 busy;

    modport slave (
        input  s_data, s_valid, m_ready, net_class, net_valid,
        output s_ready, m_data, m_valid, res_class, res_id, res_timeout,
               res_valid, stray_err, busy
    );

    modport master (
        output s_data, s_valid, m_ready, net_class, net_valid,
        input  s_ready, m_data, m_valid, res_class, res_id, res_timeout,
               res_valid, stray_err, busy
    );
endinterface

// File: rtl/image_frame_streamer.sv
// Buffers host pixel frames in a ping-pong RAM, replays one frame at a time into the CNN,
// and reports the network's class (or a timeout marker) tagged with a frame ID.
module image_frame_streamer #(
    parameter int DATA_BITS      = 8,
    parameter int HEIGHT         = 28,
    parameter int WIDTH          = 28,
    parameter int ID_BITS        = 8,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                 clk,
    input  logic                 rst_n,
    image_frame_streamer_if.slave bus
);
    localparam int FRAME_PIX = HEIGHT * WIDTH;
    localparam int WR_W      = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam int RD_W      = $clog2(FRAME_PIX + 1);
    localparam int ADDR_W    = $clog2(2 * FRAME_PIX);
    localparam int TMO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [WR_W-1:0]   WR_LAST  = WR_W'(FRAME_PIX - 1);
    localparam logic [RD_W-1:0]   RD_END   = RD_W'(FRAME_PIX);
    localparam logic [ADDR_W-1:0] BUF1_OFS = ADDR_W'(FRAME_PIX);
    localparam logic [TMO_W-1:0]  TMO_TERM = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        WAIT_RES,
        REPORT
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          full_q, full_d;
    logic                fill_sel_q, fill_sel_d;
    logic                drain_sel_q, drain_sel_d;
    logic [WR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [RD_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [ID_BITS-1:0]  id_q, id_d;
    logic [3:0]          res_class_q, res_class_d;
    logic [ID_BITS-1:0]  res_id_q, res_id_d;
    logic                res_timeout_q, res_timeout_d;
    logic                stray_q, stray_d;
    logic                rdy_en_q;

    logic [DATA_BITS-1:0] mem [0:2*FRAME_PIX-1];
    logic [DATA_BITS-1:0] rd_data_q;

    logic                 s_ready_w;
    logic                 wr_fire;
    logic [ADDR_W-1:0]    wr_addr;
    logic [ADDR_W-1:0]    rd_base;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 rd_en;

    // rdy_en_q keeps s_ready low while reset is asserted and for the first cycle after.
    assign s_ready_w = rdy_en_q & ~full_q[fill_sel_q];
    assign wr_fire   = bus.s_valid & s_ready_w;
    assign wr_addr   = (fill_sel_q ? BUF1_OFS : '0) + ADDR_W'(wr_ptr_q);
    assign rd_base   = drain_sel_q ? BUF1_OFS : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        full_d        = full_q;
        fill_sel_d    = fill_sel_q;
        drain_sel_d   = drain_sel_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        tmo_cnt_d     = tmo_cnt_q;
        id_d          = id_q;
        res_class_d   = res_class_q;
        res_id_d      = res_id_q;
        res_timeout_d = res_timeout_q;
        rd_en         = 1'b0;
        rd_addr       = rd_base;
        stray_d       = stray_q | (bus.net_valid & (state_q != WAIT_RES));

        case (state_q)
            IDLE: begin
                if (full_q[drain_sel_q]) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                rd_en    = 1'b1;
                rd_ptr_d = RD_W'(1);
                state_d  = STREAM;
            end
            STREAM: begin
                // rd_data_q only reloads on a transfer, so it doubles as the hold register.
                if (bus.m_ready) begin
                    if (rd_ptr_q == RD_END) begin
                        state_d   = WAIT_RES;
                        tmo_cnt_d = '0;
                    end else begin
                        rd_en    = 1'b1;
                        rd_addr  = rd_base + ADDR_W'(rd_ptr_q);
                        rd_ptr_d = rd_ptr_q + RD_W'(1);
                    end
                end
            end
            WAIT_RES: begin
                if (bus.net_valid) begin
                    res_class_d   = bus.net_class;
                    res_timeout_d = 1'b0;
                    res_id_d      = id_q;
                    state_d       = REPORT;
                end else if (tmo_cnt_q == TMO_TERM) begin
                    res_class_d   = 4'hF;
                    res_timeout_d = 1'b1;
                    res_id_d      = id_q;
                    state_d       = REPORT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            REPORT: begin
                full_d[drain_sel_q] = 1'b0;
                drain_sel_d         = ~drain_sel_q;
                id_d                = id_q + ID_BITS'(1);
                state_d             = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The fill buffer is never full, so this set can't collide with the REPORT clear.
        if (wr_fire) begin
            if (wr_ptr_q == WR_LAST) begin
                full_d[fill_sel_q] = 1'b1;
                wr_ptr_d           = '0;
                fill_sel_d         = ~fill_sel_q;
            end else begin
                wr_ptr_d = wr_ptr_q + WR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q        <= '0;
            fill_sel_q    <= 1'b0;
            drain_sel_q   <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tmo_cnt_q     <= '0;
            id_q          <= '0;
            res_class_q   <= '0;
            res_id_q      <= '0;
            res_timeout_q <= 1'b0;
            stray_q       <= 1'b0;
            rdy_en_q      <= 1'b0;
        end else begin
            full_q        <= full_d;
            fill_sel_q    <= fill_sel_d;
            drain_sel_q   <= drain_sel_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tmo_cnt_q     <= tmo_cnt_d;
            id_q          <= id_d;
            res_class_q   <= res_class_d;
            res_id_q      <= res_id_d;
            res_timeout_q <= res_timeout_d;
            stray_q       <= stray_d;
            rdy_en_q      <= 1'b1;
        end
    end

    // Pixel RAM: write from the fill side, synchronous read for the drain side.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= bus.s_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign bus.s_ready     = s_ready_w;
    assign bus.m_valid     = (state_q == STREAM);
    assign bus.m_data      = (state_q == STREAM) ? rd_data_q : '0;
    assign bus.res_valid   = (state_q == REPORT);
    assign bus.res_class   = res_class_q;
    assign bus.res_id      = res_id_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.stray_err   = stray_q;
    assign bus.busy        = full_q[0] | full_q[1] | (state_q != IDLE);
endmodule

// File: tb/tb_image_frame_streamer.sv
// Scoreboard bench for image_frame_streamer: pixels and results are queued as stimulus
// is driven and compared as the streamer emits them.
module tb_image_frame_streamer;
    localparam int DATA_BITS = 8;
    localparam int HEIGHT    = 28;
    localparam int WIDTH     = 28;
    localparam int ID_BITS   = 8;
    localparam int TMO       = 64;
    localparam int FRAME_PIX = HEIGHT * WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    image_frame_streamer_if #(.DATA_BITS(DATA_BITS), .ID_BITS(ID_BITS)) bus ();

    image_frame_streamer #(
        .DATA_BITS(DATA_BITS), .HEIGHT(HEIGHT), .WIDTH(WIDTH),
        .ID_BITS(ID_BITS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct packed {
        logic [3:0]         cls;
        logic [ID_BITS-1:0] id;
        logic               tmo;
    } res_t;

    logic [DATA_BITS-1:0] pix_q [$];
    res_t                 res_q [$];
    int checks = 0;
    int errors = 0;
    int exp_id = 0;
    int b2b_sent = 0;

    function automatic logic [7:0] pix_val(input int f, input int i);
        if (f == 0) return 8'(i % 256);
        return 8'((i * (2 * f + 1) + 11 * f) % 256);
    endfunction

    task automatic send_byte(input logic [7:0] d);
        bit acc = 0;
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (!acc && n < 5000) begin
            @(negedge clk);
            acc = bus.s_ready;
            @(posedge clk); #1;
            n++;
        end
        bus.s_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL s_ready_wait: byte %0d not accepted within %0d cycles", d, n);
        end else begin
            pix_q.push_back(d);
            b2b_sent++;
        end
    endtask

    task automatic send_frame(input int f);
        for (int i = 0; i < FRAME_PIX; i++) send_byte(pix_val(f, i));
    endtask

    task automatic drain(input int pct, input int nbeats, output int first_cyc, output int last_cyc);
        int beats = 0;
        int cyc = 0;
        bit held = 0;
        logic [7:0] hv = '0;
        logic [7:0] ev;
        first_cyc = -1;
        last_cyc = -1;
        while (beats < nbeats && cyc < 20000) begin
            bus.m_ready = (int'($urandom_range(99, 0)) < pct);
            @(negedge clk);
            if (held) begin
                checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== hv) begin
                    errors++;
                    $display("FAIL hold: m_valid=%0b m_data=%0d, required m_valid=1 m_data=%0d",
                             bus.m_valid, bus.m_data, hv);
                end
                held = 0;
            end
            if (bus.m_valid === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (bus.m_ready) begin
                    checks++;
                    if (pix_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_pixel: m_data=%0d with no pixel expected", bus.m_data);
                    end else begin
                        ev = pix_q.pop_front();
                        if (bus.m_data !== ev) begin
                            errors++;
                            $display("FAIL pixel %0d: m_data=%0d, required %0d", beats, bus.m_data, ev);
                        end
                    end
                    beats++;
                    last_cyc = cyc;
                end else begin
                    held = 1;
                    hv = bus.m_data;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (beats < nbeats) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d beats seen, required %0d", beats, nbeats);
        end
    endtask

    task automatic net_pulse(input logic [3:0] c);
        res_q.push_back('{cls: c, id: ID_BITS'(exp_id), tmo: 1'b0});
        exp_id++;
        bus.net_valid = 1'b1;
        bus.net_class = c;
        @(posedge clk); #1;
        bus.net_valid = 1'b0;
        bus.net_class = '0;
    endtask

    task automatic wait_result(input int maxc, output int waited, output logic rdy_rep, output logic rdy_after);
        bit got = 0;
        res_t ex;
        waited = 0;
        rdy_rep = 1'bx;
        rdy_after = 1'bx;
        while (!got && waited < maxc) begin
            @(negedge clk);
            waited++;
            if (bus.res_valid === 1'b1) got = 1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL result_wait: no res_valid within %0d cycles", maxc);
        end else if (res_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: res_class=%0h res_id=%0d", bus.res_class, bus.res_id);
        end else begin
            ex = res_q.pop_front();
            rdy_rep = bus.s_ready;
            if (bus.res_class !== ex.cls || bus.res_id !== ex.id || bus.res_timeout !== ex.tmo) begin
                errors++;
                $display("FAIL result: class=%0h id=%0d timeout=%0b, required class=%0h id=%0d timeout=%0b",
                         bus.res_class, bus.res_id, bus.res_timeout, ex.cls, ex.id, ex.tmo);
            end
            @(posedge clk); #1;
            @(negedge clk);
            rdy_after = bus.s_ready;
            checks++;
            if (bus.res_valid !== 1'b0 || bus.res_class !== ex.cls || bus.res_id !== ex.id) begin
                errors++;
                $display("FAIL result_hold: res_valid=%0b class=%0h id=%0d, required 0/%0h/%0d",
                         bus.res_valid, bus.res_class, bus.res_id, ex.cls, ex.id);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        bus.net_valid = 1'b0;
        bus.net_class = '0;
        pix_q.delete();
        res_q.delete();
        exp_id = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_data !== '0 ||
            bus.res_valid !== 1'b0 || bus.res_class !== '0 || bus.res_id !== '0 ||
            bus.res_timeout !== 1'b0 || bus.stray_err !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: s_ready=%0b m_valid=%0b m_data=%0d res_valid=%0b class=%0h id=%0d tmo=%0b stray=%0b busy=%0b, required all 0",
                     tag, bus.s_ready, bus.m_valid, bus.m_data, bus.res_valid, bus.res_class,
                     bus.res_id, bus.res_timeout, bus.stray_err, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: s_ready=%0b, required 1", bus.s_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame();
        int fc, lc, w;
        logic r0, r1;
        send_frame(0);
        drain(100, FRAME_PIX, fc, lc);
        checks++;
        if (fc != 2) begin
            errors++;
            $display("FAIL first_valid_latency: %0d cycles, required 2", fc);
        end
        checks++;
        if (lc - fc != FRAME_PIX - 1) begin
            errors++;
            $display("FAIL stream_bubbles: span %0d cycles, required %0d", lc - fc, FRAME_PIX - 1);
        end
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_end: m_valid=%0b busy=%0b, required 0 and 1", bus.m_valid, bus.busy);
        end
        @(posedge clk); #1;
        net_pulse(4'd7);
        wait_result(10, w, r0, r1);
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL result_latency: %0d cycles, required 1", w);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: busy=%0b, required 0", bus.busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random_ready();
        int fc, lc, w;
        logic r0, r1;
        send_frame(1);
        drain(50, FRAME_PIX, fc, lc);
        @(negedge clk);
        checks++;
        if (bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_frame_end: m_valid=%0b, required 0", bus.m_valid);
        end
        @(posedge clk); #1;
        repeat (3) begin @(posedge clk); #1; end
        net_pulse(4'd2);
        wait_result(10, w, r0, r1);
    endtask

    task automatic test_timeout();
        int fc, lc, w;
        logic r0, r1;
        send_frame(2);
        drain(100, FRAME_PIX, fc, lc);
        res_q.push_back('{cls: 4'hF, id: ID_BITS'(exp_id), tmo: 1'b1});
        exp_id++;
        wait_result(TMO + 20, w, r0, r1);
        checks++;
        if (w != TMO + 1) begin
            errors++;
            $display("FAIL timeout_latency: %0d cycles, required %0d", w, TMO + 1);
        end
        send_frame(3);
        drain(100, FRAME_PIX, fc, lc);
        checks++;
        if (fc != 2) begin
            errors++;
            $display("FAIL post_timeout_stream: first valid at %0d, required 2", fc);
        end
        net_pulse(4'd9);
        wait_result(10, w, r0, r1);
    endtask

    task automatic test_stray();
        int seen = 0;
        bus.net_valid = 1'b1;
        bus.net_class = 4'd5;
        @(posedge clk); #1;
        bus.net_valid = 1'b0;
        bus.net_class = '0;
        @(negedge clk);
        checks++;
        if (bus.stray_err !== 1'b1) begin
            errors++;
            $display("FAIL stray_set: stray_err=%0b, required 1", bus.stray_err);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.res_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || bus.stray_err !== 1'b1) begin
            errors++;
            $display("FAIL stray_sticky: res_valid pulses=%0d stray_err=%0b, required 0 and 1", seen, bus.stray_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_stream();
        int fc, lc, w;
        logic r0, r1;
        send_frame(4);
        drain(100, 300, fc, lc);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_stream");
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        pix_q.delete();
        res_q.delete();
        exp_id = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        send_frame(5);
        drain(100, FRAME_PIX, fc, lc);
        net_pulse(4'd1);
        wait_result(10, w, r0, r1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        b2b_sent = 0;
        fork
            begin
                for (int f = 0; f < 3; f++) begin
                    for (int i = 0; i < FRAME_PIX; i++) begin
                        send_byte(pix_val(6 + f, i));
                        if (f == 1 && i == FRAME_PIX - 1) begin
                            @(negedge clk);
                            checks++;
                            if (bus.s_ready !== 1'b0) begin
                                errors++;
                                $display("FAIL backpressure: s_ready=%0b after byte %0d, required 0",
                                         bus.s_ready, b2b_sent);
                            end
                            @(posedge clk); #1;
                        end
                    end
                end
            end
            begin
                int n = 0;
                int fc, lc, w;
                logic r0, r1;
                bus.m_ready = 1'b0;
                while (b2b_sent < 2 * FRAME_PIX && n < 10000) begin
                    @(posedge clk); #1;
                    n++;
                end
                for (int f = 0; f < 3; f++) begin
                    drain(100, FRAME_PIX, fc, lc);
                    repeat (5) begin @(posedge clk); #1; end
                    net_pulse(4'(3 + f));
                    wait_result(10, w, r0, r1);
                    if (f == 0) begin
                        checks++;
                        if (r0 !== 1'b0 || r1 !== 1'b1) begin
                            errors++;
                            $display("FAIL ready_release: s_ready at report=%0b after=%0b, required 0 then 1", r0, r1);
                        end
                    end
                end
            end
        join
    endtask

    initial begin
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.m_ready   = 1'b0;
        bus.net_valid = 1'b0;
        bus.net_class = '0;
        test_reset();
        test_single_frame();
        test_random_ready();
        test_timeout();
        test_stray();
        test_reset_mid_stream();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
